// File: rtl/frame_buf_sched.sv
// frame_buf_sched: triple-buffer frame scheduler handing DDR buffers to the write and read DMAs.
module frame_buf_sched #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(32'h001C_2000),
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              wr_fs_i,
    input  logic              rd_fs_i,
    input  logic              wr_busy_i,
    output logic              wr_start_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [1:0]        wr_idx_o,
    output logic              rd_start_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [1:0]        rd_idx_o,
    output logic              frame_valid_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic [CNT_W-1:0]  repeat_cnt_o
);
    typedef enum logic [1:0] {IDLE, WAIT_FIRST, RUN} state_t;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [1:0] idx);
        return BASE_ADDR + ADDR_W'(idx) * FRAME_SIZE;
    endfunction

    state_t            r_state;
    logic [1:0]        r_wr_idx, r_rd_idx, r_latest;
    logic              r_fresh, r_fv, r_wr_active, r_wr_start, r_rd_start;
    logic [ADDR_W-1:0] r_wr_addr, r_rd_addr;
    logic [CNT_W-1:0]  r_drop, r_repeat;

    logic       w_run, w_wr_done, w_wr_drop, w_rd, w_rd_new;
    logic [1:0] w_wr_next, w_rd_src;

    assign w_run     = r_state == RUN && en_i;
    assign w_wr_done = w_run && wr_fs_i && !wr_busy_i && r_wr_active;
    assign w_wr_drop = w_run && wr_fs_i && wr_busy_i;
    // a same-cycle promotion is visible to the read before it is committed
    assign w_rd      = w_run && rd_fs_i && (r_fv || w_wr_done);
    assign w_rd_new  = r_fresh || w_wr_done;
    assign w_rd_src  = w_wr_done ? r_wr_idx : r_latest;
    assign w_wr_next = 2'd3 - r_wr_idx - r_rd_idx;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_wr_idx    <= 2'd0;
            r_rd_idx    <= 2'd1;
            r_latest    <= 2'd1;
            r_fresh     <= 1'b0;
            r_fv        <= 1'b0;
            r_wr_active <= 1'b0;
            r_wr_start  <= 1'b0;
            r_rd_start  <= 1'b0;
            r_wr_addr   <= addr_of(2'd0);
            r_rd_addr   <= addr_of(2'd1);
            r_drop      <= '0;
            r_repeat    <= '0;
        end else begin
            r_wr_start <= 1'b0;
            r_rd_start <= 1'b0;
            if (r_state == IDLE) begin
                if (en_i) r_state <= WAIT_FIRST;
            end else if (!en_i) begin
                r_state     <= IDLE;
                r_wr_idx    <= 2'd0;
                r_rd_idx    <= 2'd1;
                r_latest    <= 2'd1;
                r_fresh     <= 1'b0;
                r_fv        <= 1'b0;
                r_wr_active <= 1'b0;
                r_wr_addr   <= addr_of(2'd0);
                r_rd_addr   <= addr_of(2'd1);
            end else if (r_state == WAIT_FIRST) begin
                if (wr_fs_i) begin
                    r_wr_start  <= 1'b1;
                    r_wr_active <= 1'b1;
                    r_state     <= RUN;
                end
            end else begin
                if (w_wr_done) begin
                    r_latest   <= r_wr_idx;
                    r_fresh    <= 1'b1;
                    r_fv       <= 1'b1;
                    r_wr_idx   <= w_wr_next;
                    r_wr_addr  <= addr_of(w_wr_next);
                    r_wr_start <= 1'b1;
                end
                if (w_wr_drop) begin
                    r_wr_start <= 1'b1;
                    if (r_drop != '1) r_drop <= r_drop + CNT_W'(1);
                end
                if (w_rd) begin
                    r_rd_start <= 1'b1;
                    if (w_rd_new) begin
                        r_rd_idx  <= w_rd_src;
                        r_rd_addr <= addr_of(w_rd_src);
                        r_fresh   <= 1'b0;
                    end else if (r_repeat != '1) begin
                        r_repeat <= r_repeat + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign wr_start_o    = r_wr_start;
    assign wr_addr_o     = r_wr_addr;
    assign wr_idx_o      = r_wr_idx;
    assign rd_start_o    = r_rd_start;
    assign rd_addr_o     = r_rd_addr;
    assign rd_idx_o      = r_rd_idx;
    assign frame_valid_o = r_fv;
    assign drop_cnt_o    = r_drop;
    assign repeat_cnt_o  = r_repeat;
endmodule

// File: tb/tb_frame_buf_sched.sv
// tb_frame_buf_sched: random fs stimulus against a frame-level model of the triple buffer.
module tb_frame_buf_sched;
    localparam int ADDR_W = 32;
    localparam int CNT_W = 4;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] FSZ = 32'h001C_2000;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk_i = 0, rst_i = 1, en_i = 0, wr_fs_i = 0, rd_fs_i = 0, wr_busy_i = 0;
    logic wr_start_o, rd_start_o, frame_valid_o;
    logic [ADDR_W-1:0] wr_addr_o, rd_addr_o;
    logic [1:0] wr_idx_o, rd_idx_o;
    logic [CNT_W-1:0] drop_cnt_o, repeat_cnt_o;

    frame_buf_sched #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FRAME_SIZE(FSZ), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .wr_fs_i(wr_fs_i), .rd_fs_i(rd_fs_i),
        .wr_busy_i(wr_busy_i), .wr_start_o(wr_start_o), .wr_addr_o(wr_addr_o),
        .wr_idx_o(wr_idx_o), .rd_start_o(rd_start_o), .rd_addr_o(rd_addr_o),
        .rd_idx_o(rd_idx_o), .frame_valid_o(frame_valid_o), .drop_cnt_o(drop_cnt_o),
        .repeat_cnt_o(repeat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0, n_err = 0, n_fs = 0;
    int m_mode, m_wr, m_rd, m_lat, m_fresh, m_fv, m_drop, m_rep, m_ws, m_rs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int free_buf(input int a, input int b);
        for (int i = 0; i < 3; i++) if (i != a && i != b) return i;
        return -1;
    endfunction

    task automatic model_reset(input bit counters);
        m_mode = 0; m_wr = 0; m_rd = 1; m_lat = 1; m_fresh = 0; m_fv = 0; m_ws = 0; m_rs = 0;
        if (counters) begin m_drop = 0; m_rep = 0; end
    endtask

    // mode 0 idle, 1 waiting for the first write frame, 2 running
    task automatic model_step(input bit en, input bit wr, input bit rd, input bit busy);
        int nw;
        m_ws = 0; m_rs = 0;
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (!en) begin
            model_reset(0);
        end else if (m_mode == 1) begin
            if (wr) begin m_ws = 1; m_mode = 2; end
        end else begin
            if (wr) begin
                m_ws = 1;
                if (busy) m_drop = (m_drop < CMAX) ? m_drop + 1 : CMAX;
                else begin
                    nw = free_buf(m_wr, m_rd);
                    m_lat = m_wr; m_fresh = 1; m_fv = 1; m_wr = nw;
                end
            end
            if (rd && m_fv) begin
                m_rs = 1;
                if (m_fresh) begin m_rd = m_lat; m_fresh = 0; end
                else m_rep = (m_rep < CMAX) ? m_rep + 1 : CMAX;
            end
        end
    endtask

    task automatic compare_all();
        check("wr_start", 32'(wr_start_o), 32'(m_ws));
        check("rd_start", 32'(rd_start_o), 32'(m_rs));
        check("wr_idx", 32'(wr_idx_o), 32'(m_wr));
        check("rd_idx", 32'(rd_idx_o), 32'(m_rd));
        check("wr_addr", wr_addr_o, BASE + 32'(m_wr) * FSZ);
        check("rd_addr", rd_addr_o, BASE + 32'(m_rd) * FSZ);
        check("frame_valid", 32'(frame_valid_o), 32'(m_fv));
        check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
        check("repeat_cnt", 32'(repeat_cnt_o), 32'(m_rep));
        check("idx_distinct", 32'(wr_idx_o != rd_idx_o), 32'd1);
    endtask

    task automatic step(input bit en, input bit wr, input bit rd, input bit busy);
        @(negedge clk_i);
        en_i = en; wr_fs_i = wr; rd_fs_i = rd; wr_busy_i = busy;
        @(posedge clk_i);
        model_step(en, wr, rd, busy);
        #1;
        compare_all();
    endtask

    initial begin
        model_reset(1);
        repeat (3) @(posedge clk_i);
        #1;
        compare_all();
        @(negedge clk_i);
        rst_i = 0;
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        check("first_wr_addr", wr_addr_o, 32'h0);
        step(1, 0, 1, 0);
        step(1, 1, 0, 0);
        check("second_wr_addr", wr_addr_o, 32'h0038_4000);
        step(1, 0, 1, 0);
        check("first_rd_idx", 32'(rd_idx_o), 32'd0);
        step(1, 0, 1, 0);
        check("repeat_one", 32'(repeat_cnt_o), 32'd1);
        step(1, 1, 0, 1);
        check("drop_one", 32'(drop_cnt_o), 32'd1);
        step(1, 1, 1, 0);
        check("simul_rd_idx", 32'(rd_idx_o), 32'd2);
        check("simul_wr_idx", 32'(wr_idx_o), 32'd1);
        for (int i = 0; i < 2000; i++) begin
            automatic bit en = $urandom_range(0, 149) != 0;
            automatic bit wr = $urandom_range(0, 2) == 0;
            automatic bit rd = $urandom_range(0, 2) == 0;
            automatic bit busy = $urandom_range(0, 3) == 0;
            n_fs += int'(wr) + int'(rd);
            step(en, wr, rd, busy);
        end
        step(0, 1, 1, 0);
        step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        @(negedge clk_i);
        #2 rst_i = 1;
        #1;
        model_reset(1);
        compare_all();
        @(negedge clk_i);
        rst_i = 0;
        step(1, 0, 0, 0);
        $display("random fs pulses: %0d", n_fs);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
